// File: rtl/stick_pkg.sv
// Shared mode constants, pulse FSM encoding and quadrature helpers for msync_gen.
package stick_pkg;

  localparam logic [1:0] MS_OFF   = 2'd0;
  localparam logic [1:0] MS_INT   = 2'd1;
  localparam logic [1:0] MS_WHEEL = 2'd2;
  localparam logic [1:0] MS_EXT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } pulse_st_t;

  // Position of an {a,b} pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] quad_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_idx = 2'd0;
      2'b01:   quad_idx = 2'd1;
      2'b11:   quad_idx = 2'd2;
      default: quad_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/quad_dec.sv
// Quadrature front end: synchronizer, level debounce and step/error decode.
module quad_dec
  import stick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB         = 4
) (
  input  logic clk20,
  input  logic res_n,
  input  logic adp,
  input  logic bdp,
  output logic step_fwd,
  output logic step_bwd,
  output logic qerr
);

  localparam int CW = $clog2(DEB + 1);

  logic [SYNC_STAGES-1:0] a_sr_p0, b_sr_p0;
  logic [1:0]             pair_s;
  logic [1:0]             cand_p1;
  logic [CW-1:0]          cnt_p1;
  logic [1:0]             acc_pair_p2;
  logic                   accept;
  logic [1:0]             delta;

  assign pair_s = {a_sr_p0[SYNC_STAGES-1], b_sr_p0[SYNC_STAGES-1]};

  // Stage p0: metastability synchronizers
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      a_sr_p0 <= '1;
      b_sr_p0 <= '1;
    end else begin
      a_sr_p0 <= {a_sr_p0[SYNC_STAGES-2:0], adp};
      b_sr_p0 <= {b_sr_p0[SYNC_STAGES-2:0], bdp};
    end
  end

  // Stage p1: cnt_p1 is the number of consecutive samples equal to cand_p1
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      cand_p1 <= 2'b11;
      cnt_p1  <= '0;
    end else if (pair_s != cand_p1) begin
      cand_p1 <= pair_s;
      cnt_p1  <= CW'(1);
    end else if (cnt_p1 != CW'(DEB)) begin
      cnt_p1  <= cnt_p1 + CW'(1);
    end
  end

  assign accept = (cnt_p1 == CW'(DEB)) && (cand_p1 != acc_pair_p2);
  assign delta  = quad_idx(cand_p1) - quad_idx(acc_pair_p2);

  // Stage p2: accepted pair and decoded step/error pulses
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      acc_pair_p2 <= 2'b11;
      step_fwd    <= 1'b0;
      step_bwd    <= 1'b0;
      qerr        <= 1'b0;
    end else begin
      step_fwd <= accept && (delta == 2'd1);
      step_bwd <= accept && (delta == 2'd3);
      qerr     <= accept && (delta == 2'd2);
      if (accept) acc_pair_p2 <= cand_p1;
    end
  end

endmodule

// File: rtl/msync_gen.sv
// Master sync generator: internal, wheel-driven or external triggers shaped into a
// fixed-width active-low pulse, with wheel position tracking and sticky error flags.
module msync_gen
  import stick_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int WHEEL_W     = 16,
  parameter int PW_CYCLES   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB         = 4
) (
  input  logic                clk20,
  input  logic                res_n,
  input  logic [1:0]          i_mode,
  input  logic [DIV_W-1:0]    i_period,
  input  logic [WHEEL_W-1:0]  i_wheel_div,
  input  logic [1:0]          i_dir_en,
  input  logic                i_clr,
  input  logic                adp,
  input  logic                bdp,
  input  logic                sync,
  output logic                o_msync_n,
  output logic signed [31:0]  o_pos,
  output logic                o_dir,
  output logic [15:0]         o_sync_cnt,
  output logic                o_overrun,
  output logic                o_qerr
);

  localparam int AW  = WHEEL_W + 2;
  localparam int PCW = $clog2(PW_CYCLES + 1);
  localparam logic signed [AW-1:0] ONE = AW'(1);

  logic                   step_fwd, step_bwd, qerr_pls;
  logic [SYNC_STAGES-1:0] sync_sr_p0;
  logic                   sync_s, sync_prev_p1;
  logic [1:0]             mode_prev;
  logic                   mode_chg;
  logic [DIV_W-1:0]       per_cnt, per_last;
  logic signed [AW-1:0]   acc, acc_nxt, div_s;
  logic                   int_trig, wheel_trig, ext_trig, trig;
  pulse_st_t              state_q, state_nxt;
  logic [PCW-1:0]         pw_cnt;

  quad_dec #(.SYNC_STAGES(SYNC_STAGES), .DEB(DEB)) u_quad (
    .clk20    (clk20),
    .res_n    (res_n),
    .adp      (adp),
    .bdp      (bdp),
    .step_fwd (step_fwd),
    .step_bwd (step_bwd),
    .qerr     (qerr_pls)
  );

  // Stage p0/p1: external sync synchronizer and falling-edge detect
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      sync_sr_p0   <= '1;
      sync_prev_p1 <= 1'b1;
    end else begin
      sync_sr_p0   <= {sync_sr_p0[SYNC_STAGES-2:0], sync};
      sync_prev_p1 <= sync_s;
    end
  end

  assign sync_s   = sync_sr_p0[SYNC_STAGES-1];
  assign ext_trig = (i_mode == MS_EXT) && sync_prev_p1 && !sync_s;
  assign mode_chg = (i_mode != mode_prev);

  // Short periods are stretched so a pulse plus its gap always fits.
  assign per_last = (i_period < DIV_W'(PW_CYCLES + 1)) ? DIV_W'(PW_CYCLES) : i_period - DIV_W'(1);
  assign int_trig = (i_mode == MS_INT) && (i_period != '0) && (per_cnt >= per_last);

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      mode_prev <= MS_OFF;
      per_cnt   <= '0;
    end else begin
      mode_prev <= i_mode;
      if (mode_chg || int_trig || i_mode != MS_INT || i_period == '0) per_cnt <= '0;
      else                                                          per_cnt <= per_cnt + DIV_W'(1);
    end
  end

  assign div_s = $signed({2'b00, i_wheel_div});

  // Wheel accumulator: fires and rewinds at an enabled limit, sticks at a disabled one.
  always_comb begin
    acc_nxt    = '0;
    wheel_trig = 1'b0;
    if (i_mode == MS_WHEEL && i_wheel_div != '0) begin
      acc_nxt = acc;
      if (step_fwd) begin
        if (acc + ONE >= div_s) begin
          if (i_dir_en[0]) wheel_trig = 1'b1;
          else             acc_nxt    = div_s;
        end else begin
          acc_nxt = acc + ONE;
        end
      end else if (step_bwd) begin
        if (acc - ONE <= -div_s) begin
          if (i_dir_en[1]) wheel_trig = 1'b1;
          else             acc_nxt    = -div_s;
        end else begin
          acc_nxt = acc - ONE;
        end
      end
      if (wheel_trig) acc_nxt = '0;
    end
  end

  always_ff @(posedge clk20) begin
    if (!res_n || i_clr || mode_chg) acc <= '0;
    else                             acc <= acc_nxt;
  end

  assign trig = int_trig | wheel_trig | ext_trig;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (trig) state_nxt = ST_PULSE;
      ST_PULSE: if (pw_cnt == PCW'(PW_CYCLES - 1)) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p2: pulse FSM with registered output
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      state_q   <= ST_IDLE;
      pw_cnt    <= '0;
      o_msync_n <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      pw_cnt    <= (state_q == ST_PULSE && state_nxt == ST_PULSE) ? pw_cnt + PCW'(1) : '0;
      o_msync_n <= (state_nxt != ST_PULSE);
    end
  end

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      o_pos      <= '0;
      o_dir      <= 1'b0;
      o_sync_cnt <= '0;
      o_overrun  <= 1'b0;
      o_qerr     <= 1'b0;
    end else if (i_clr) begin
      o_pos      <= '0;
      o_sync_cnt <= '0;
      o_overrun  <= 1'b0;
      o_qerr     <= 1'b0;
    end else begin
      if (step_fwd) begin
        o_pos <= o_pos + 32'sd1;
        o_dir <= 1'b0;
      end else if (step_bwd) begin
        o_pos <= o_pos - 32'sd1;
        o_dir <= 1'b1;
      end
      if (trig && state_q == ST_IDLE) o_sync_cnt <= o_sync_cnt + 16'd1;
      if (trig && state_q != ST_IDLE) o_overrun  <= 1'b1;
      if (qerr_pls)                   o_qerr     <= 1'b1;
    end
  end

endmodule
